inst_lane_queue: RTL
====================

// Module: inst_lane_queue
// PURPOSE
//  Parametrised multi-lane instruction queue decoupling ifu_top fetch lanes from exu_top issue lanes.
//  Replaces the fixed 4-lane direct valid/allowIn wiring with a DEPTH-entry in-order circular buffer.
//  Accepts up to IN_LANES instructions per cycle and presents up to OUT_LANES oldest instructions per cycle.
//  Adds a flush that empties the queue for redirects.
// PARAMETERS
//  IN_LANES   4   enqueue lanes per cycle from ifu; 1..DEPTH
//  OUT_LANES  4   dequeue lanes per cycle to exu; 1..DEPTH
//  DEPTH      16  queue entries; power of 2, >= max(IN_LANES,OUT_LANES)
//  DATA_W     32  instruction width
// PORTS
//  clk          in   1                   clock, all state on rising edge
//  rst          in   1                   synchronous active-high reset
//  flush        in   1                   synchronous queue clear (redirect)
//  in_valid     in   IN_LANES            ifu lane i holds an instruction
//  in_allowIn   out  IN_LANES            queue can take lane i this cycle
//  in_data      in   IN_LANES*DATA_W     lane i at [i*DATA_W +: DATA_W]
//  out_valid    out  OUT_LANES           exu lane j holds the j-th oldest entry
//  out_allowIn  in   OUT_LANES           exu takes lane j this cycle
//  out_data     out  OUT_LANES*DATA_W    lane j at [j*DATA_W +: DATA_W]
//  count        out  $clog2(DEPTH+1)     current occupancy (registered)
// BEHAVIOUR
//  - State: head_ptr, tail_ptr ($clog2(DEPTH) bits, wrap modulo DEPTH), count, DEPTH x DATA_W storage.
//  - Reset: head=tail=count=0; while rst=1: in_allowIn=0, out_valid=0, out_data=0, count=0.
//  - free = DEPTH - count (registered count only; no same-cycle dequeue bypass).
//  - in_allowIn[i] = !rst && (free > i). Combinational from registered state only.
//  - Enqueue: n_enq = number of leading lanes 0..k with in_valid&in_allowIn all true;
//    lanes after the first lane with valid=0 or allowIn=0 are NOT written even if valid.
//    Lane i (i<n_enq) written to storage[tail+i]; tail += n_enq.
//  - out_valid[j] = !rst && (count > j); out_data[j] = storage[head+j] if valid, else 0.
//  - Dequeue: n_deq = number of leading lanes 0..k with out_valid&out_allowIn all true;
//    out_allowIn on lane j with a lower lane not taken is ignored. head += n_deq.
//  - count_next = count + n_enq - n_deq; simultaneous enq/deq fully supported.
//  - Latency: enqueue into empty queue -> out_valid[0] one cycle later. No combinational in->out path.
//  - Full (count=DEPTH): in_allowIn all 0. Empty: out_valid all 0; out_allowIn ignored.
//  - Pointer wrap: tail+i / head+j index modulo DEPTH; entries straddling wrap kept in order.
//  - flush=1: next cycle head=tail=count=0; same-cycle enqueue/dequeue discarded (n_enq, n_deq
//    have no effect); storage contents not cleared. rst has priority over flush.
//  - Reset mid-operation: all entries dropped, identical to power-on reset.
//  - Invariants: 0 <= count <= DEPTH; out_valid and in_allowIn always thermometer-coded from lane 0.
// TESTING
//  1 Reset: rst=1 2 cycles -> in_allowIn=0, out_valid=0, count=0; after release in_allowIn=4'b1111.
//  2 Fill: in_valid=1111 data 0..3 for 4 cycles, out_allowIn=0 -> count=16, in_allowIn=0000,
//    out_data lanes = 0,1,2,3; 5th push not accepted.
//  3 Gap: in_valid=4'b1101 into empty queue -> only lane 0 written, count=1; 
//    out_allowIn=4'b1110 with count=4 -> nothing dequeued.
//  4 Wrap+concurrent: DEPTH=16, head=14, count=2; enq 4 and deq 2 same cycle -> count=4,
//    head=0, tail=4, out_data order preserved across wrap.
//  5 Flush: count=9, flush=1 with in_valid=1111 -> next cycle count=0, out_valid=0000,
//    in_allowIn=1111; following push visible one cycle later.
//  6 Random: IN_LANES=2, OUT_LANES=3, DEPTH=8, random valid/allowIn 10k cycles ->
//    scoreboard in-order match, no loss/duplication, count never >8.

Source files
------------

// File: rtl/inst_lane_queue.sv
// ---------------------------------------------------------------------------
// inst_lane_queue
//   Multi-lane in-order instruction queue sitting between the fetch lanes and
//   the issue lanes. Up to IN_LANES instructions are accepted per cycle and up
//   to OUT_LANES of the oldest entries are presented per cycle, backed by a
//   DEPTH-entry circular buffer. A flush empties the queue on a redirect.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   flush        synchronous queue clear (redirect)
//   in_valid     per-lane: fetch lane i presents an instruction
//   in_allowIn   per-lane: queue can take lane i this cycle
//   in_data      lane i at [i*DATA_W +: DATA_W]
//   out_valid    per-lane: issue lane j holds the j-th oldest entry
//   out_allowIn  per-lane: issue lane j takes its entry this cycle
//   out_data     lane j at [j*DATA_W +: DATA_W], zero when not valid
//   count        registered occupancy
//
// DEPTH must be a power of two (pointers wrap by natural overflow), at least
// 2, and no smaller than either lane count.
// ---------------------------------------------------------------------------
module inst_lane_queue #(
    parameter int IN_LANES  = 4,
    parameter int OUT_LANES = 4,
    parameter int DEPTH     = 16,
    parameter int DATA_W    = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [IN_LANES-1:0]           in_valid,
    output logic [IN_LANES-1:0]           in_allowIn,
    input  logic [IN_LANES*DATA_W-1:0]    in_data,
    output logic [OUT_LANES-1:0]          out_valid,
    input  logic [OUT_LANES-1:0]          out_allowIn,
    output logic [OUT_LANES*DATA_W-1:0]   out_data,
    output logic [$clog2(DEPTH+1)-1:0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] storage [DEPTH];
    logic [PTR_W-1:0]  headPtr;
    logic [PTR_W-1:0]  tailPtr;
    logic [CNT_W-1:0]  freeSlots;
    logic [CNT_W-1:0]  nEnq;
    logic [CNT_W-1:0]  nDeq;

    // Free space comes from the registered count only: a slot released by a
    // dequeue this cycle is not offered to the fetch side until next cycle,
    // which keeps in_allowIn free of any path from out_allowIn.
    assign freeSlots = CNT_W'(DEPTH) - count;

    // Enqueue side: in_allowIn is a thermometer from lane 0. Acceptance stops
    // at the first lane that is not both valid and allowed, so instructions
    // behind a bubble are never written and program order is preserved.
    always_comb begin : enqLanes
        logic run;
        logic laneOk;
        run        = 1'b1;
        laneOk     = 1'b0;
        nEnq       = '0;
        in_allowIn = '0;
        for (int i = 0; i < IN_LANES; i++) begin
            laneOk        = !rst && (32'(freeSlots) > i);
            in_allowIn[i] = laneOk;
            if (run && in_valid[i] && laneOk) begin
                nEnq = nEnq + CNT_W'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

    // Dequeue side: lane j shows the j-th oldest entry. As with enqueue, a
    // take on lane j only counts if every lower lane was also taken.
    always_comb begin : deqLanes
        logic run;
        logic laneVld;
        run       = 1'b1;
        laneVld   = 1'b0;
        nDeq      = '0;
        out_valid = '0;
        out_data  = '0;
        for (int j = 0; j < OUT_LANES; j++) begin
            laneVld      = !rst && (32'(count) > j);
            out_valid[j] = laneVld;
            if (laneVld) begin
                out_data[j*DATA_W +: DATA_W] = storage[headPtr + PTR_W'(j)];
            end
            if (run && laneVld && out_allowIn[j]) begin
                nDeq = nDeq + CNT_W'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

    // Control state. rst wins over flush; both drop every entry and discard
    // whatever enqueue/dequeue was happening in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
        end else begin
            headPtr <= headPtr + PTR_W'(nDeq);
            tailPtr <= tailPtr + PTR_W'(nEnq);
            count   <= count + nEnq - nDeq;
        end
    end

    // Storage is never cleared; entries are only meaningful between head and
    // tail. Writes are suppressed on flush so a discarded enqueue leaves no
    // trace. Under rst nEnq is already zero because in_allowIn is forced low.
    always_ff @(posedge clk) begin
        if (!flush) begin
            for (int i = 0; i < IN_LANES; i++) begin
                if (32'(nEnq) > i) begin
                    storage[tailPtr + PTR_W'(i)] <= in_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule
